// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared state encoding and protocol byte constants for the UART debug bus master.
package uart_dbg_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, ACCESS, RDWAIT, RESP, TXWAIT} state_e;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;
endpackage

// File: rtl/uart_dbg_timeout.sv
// uart_dbg_timeout: inter-byte timeout counter; expired_o pulses after TIMEOUT_CYCLES enabled cycles without a clear.
module uart_dbg_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q;
  assign expired_o = en_i && cnt_q == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: decodes 'W'/'R' commands from the UART byte stream, performs one 32-bit bus access
// under a CPU hold grant, and replies with 'K', read data, or '?' through the UART transmitter.
module uart_bus_master
  import uart_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tx_write,
  output logic [7:0]  tx_data,
  input  logic        tx_finished,
  output logic        hold_req,
  input  logic        hold_gnt,
  output logic        bus_req,
  output logic        bus_wren,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        overrun
);
  state_e      state_q;
  logic        op_wr_q, hold_req_q, bus_req_q, bus_wren_q, tx_write_q, overrun_q;
  logic [1:0]  cnt_q, lat_q, rsp_left_q;
  logic [31:0] addr_q, wdata_q, rsp_q;
  logic        rx_phase, expired;
  assign rx_phase  = state_q == ADDR || state_q == DATA;
  assign tx_write  = tx_write_q;
  assign tx_data   = rsp_q[7:0];
  assign hold_req  = hold_req_q;
  assign bus_req   = bus_req_q;
  assign bus_wren  = bus_wren_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = state_q != IDLE;
  assign overrun   = overrun_q;
  uart_dbg_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .reset(reset), .clr_i(rx_ready || !rx_phase), .en_i(rx_phase), .expired_o(expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      hold_req_q <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_wren_q <= 1'b0;
      tx_write_q <= 1'b0;
      overrun_q  <= 1'b0;
      cnt_q      <= '0;
      lat_q      <= '0;
      rsp_left_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_q      <= '0;
    end else begin
      tx_write_q <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_wren_q <= 1'b0;
      if (rx_ready && state_q inside {HOLD, ACCESS, RDWAIT, RESP, TXWAIT}) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (rx_ready) begin
          op_wr_q    <= rx_data == CMD_WRITE;
          cnt_q      <= '0;
          rsp_q      <= {24'd0, RSP_ERR};
          rsp_left_q <= '0;
          state_q    <= (rx_data == CMD_WRITE || rx_data == CMD_READ) ? ADDR : RESP;
        end
        // Address low bits are dropped on every shift so bus_addr is always word aligned.
        ADDR: if (expired) state_q <= IDLE;
        else if (rx_ready) begin
          addr_q <= {rx_data, addr_q[31:10], 2'b00};
          cnt_q  <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q    <= op_wr_q ? DATA : HOLD;
            hold_req_q <= !op_wr_q;
          end
        end
        DATA: if (expired) state_q <= IDLE;
        else if (rx_ready) begin
          wdata_q <= {rx_data, wdata_q[31:8]};
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q    <= HOLD;
            hold_req_q <= 1'b1;
          end
        end
        HOLD: if (hold_gnt) begin
          state_q    <= ACCESS;
          bus_req_q  <= 1'b1;
          bus_wren_q <= op_wr_q;
        end
        ACCESS: begin
          lat_q      <= '0;
          rsp_q      <= {24'd0, RSP_ACK};
          rsp_left_q <= '0;
          hold_req_q <= !op_wr_q;
          state_q    <= op_wr_q ? RESP : RDWAIT;
        end
        RDWAIT: if (lat_q == 2'(RD_LATENCY - 1)) begin
          rsp_q      <= bus_rdata;
          rsp_left_q <= 2'd3;
          hold_req_q <= 1'b0;
          state_q    <= RESP;
        end else lat_q <= lat_q + 2'd1;
        RESP: begin
          tx_write_q <= 1'b1;
          state_q    <= TXWAIT;
        end
        TXWAIT: if (tx_finished) begin
          rsp_q      <= rsp_q >> 8;
          rsp_left_q <= rsp_left_q - 2'd1;
          state_q    <= rsp_left_q != 2'd0 ? RESP : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed command sequence with bus and UART reply scoreboards.
module tb_uart_bus_master;
  localparam int TO = 200;
  logic        clk = 1'b0, reset = 1'b1, rx_ready = 1'b0, tx_finished = 1'b0, hold_gnt = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] bus_rdata = 32'h0, rd_val = 32'h0;
  logic        tx_write, hold_req, bus_req, bus_wren, busy, overrun;
  logic [7:0]  tx_data;
  logic [31:0] bus_addr, bus_wdata;
  int checks = 0, errors = 0, hold_cnt = 0;
  typedef struct {logic wren; logic [31:0] addr; logic [31:0] wdata;} acc_t;
  acc_t busq[$];
  logic [7:0] txq[$];

  uart_bus_master #(.TIMEOUT_CYCLES(TO), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_write(tx_write), .tx_data(tx_data), .tx_finished(tx_finished),
    .hold_req(hold_req), .hold_gnt(hold_gnt), .bus_req(bus_req), .bus_wren(bus_wren),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus slave: read data valid exactly one cycle after the bus_req cycle.
  always @(posedge clk) bus_rdata <= (bus_req && !bus_wren) ? rd_val : 32'h0;

  always @(negedge clk) if (hold_req) hold_cnt++;

  always @(negedge clk)
    if (!reset && bus_req) begin
      acc_t e;
      chk("bus_unexp", busq.size() != 0, 1);
      if (busq.size() != 0) begin
        e = busq.pop_front();
        chk("bus_wren", bus_wren, e.wren);
        chk("bus_addr", bus_addr, e.addr);
        if (e.wren) chk("bus_wdata", bus_wdata, e.wdata);
      end
      chk("hold_at_req", hold_req, 1);
    end

  initial forever begin
    @(negedge clk);
    if (!reset && tx_write) begin
      chk("tx_unexp", txq.size() != 0, 1);
      if (txq.size() != 0) chk("tx_data", tx_data, txq.pop_front());
      chk("hold_in_tx", hold_req, 0);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (tx_write) chk("tx_early", tx_write, 0);
      end
      tx_finished = 1'b1;
      @(negedge clk);
      tx_finished = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    send(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
  endtask

  task automatic expect_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    acc_t e;
    e.wren  = wr;
    e.addr  = a;
    e.wdata = d;
    busq.push_back(e);
    if (wr) txq.push_back(8'h4B);
    else for (int i = 0; i < 4; i++) txq.push_back(d[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
    chk({tag, "_pending"}, txq.size() + busq.size(), 0);
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (!tx_write && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, tx_write, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx_write"}, tx_write, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_hold_req"}, hold_req, 0);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_bus_wren"}, bus_wren, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int bad, h0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    expect_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    wait_idle("wr");

    rd_val = 32'h1234_5678;
    expect_cmd(1'b0, 32'h0000_0020, rd_val);
    send_cmd(1'b0, 32'h0000_0020, 32'h0);
    wait_idle("rd");

    hold_gnt = 1'b0;
    rd_val = 32'hA5A5_5A5A;
    expect_cmd(1'b0, 32'h0000_0030, rd_val);
    send_cmd(1'b0, 32'h0000_0030, 32'h0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!hold_req || bus_req) bad++;
    end
    chk("gnt_wait", bad, 0);
    hold_gnt = 1'b1;
    @(negedge clk);
    chk("gnt_req", bus_req, 1);
    wait_idle("gnt");

    h0 = hold_cnt;
    txq.push_back(8'h3F);
    send(8'h41);
    wait_idle("bad");
    chk("bad_hold", hold_cnt - h0, 0);
    rd_val = 32'hCAFE_F00D;
    expect_cmd(1'b0, 32'h0000_0044, rd_val);
    send_cmd(1'b0, 32'h0000_0047, 32'h0);
    wait_idle("rd_align");

    send(8'h57);
    send(8'h10);
    send(8'h00);
    repeat (TO + 5) @(negedge clk);
    chk("to_busy", busy, 0);
    chk("to_pending", txq.size() + busq.size(), 0);
    expect_cmd(1'b1, 32'h0000_0080, 32'h0102_0304);
    send_cmd(1'b1, 32'h0000_0080, 32'h0102_0304);
    wait_idle("to_wr");
    chk("ovr_clear", overrun, 0);

    rd_val = 32'h1122_3344;
    expect_cmd(1'b0, 32'h0000_0050, rd_val);
    send_cmd(1'b0, 32'h0000_0050, 32'h0);
    wait_tx("ovr_tx1");
    rx_data  = 8'h99;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("ovr_set", overrun, 1);
    wait_tx("ovr_tx2");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("mid_rst");
    txq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    expect_cmd(1'b1, 32'h0000_0004, 32'h1234_5678);
    send_cmd(1'b1, 32'h0000_0004, 32'h1234_5678);
    wait_idle("post_rst");
    chk("post_ovr", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
